// File: rtl/neopixel_pkg.sv
// ============================================================================
// neopixel_pkg: shared state encoding and timing constants for the Neopixel TX path
// Rev 1.0
// ============================================================================
`default_nettype none

package neopixel_pkg;

    localparam int unsigned NUM_REQ          = 2;
    localparam int unsigned TIMER_W          = 16;
    localparam int unsigned DEF_TAIL_CYCLES  = 720;
    localparam int unsigned DEF_LATCH_CYCLES = 1200;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_TAIL  = 3'd3,
        ST_LATCH = 3'd4
    } state_e;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        return {idx, ~idx};
    endfunction

endpackage

`default_nettype wire

// File: rtl/neopixel_cycle_timer.sv
// ============================================================================
// neopixel_cycle_timer: loadable down-counter with zero flag, shared by TAIL and LATCH
// Rev 1.0
// ============================================================================
`default_nettype none

module neopixel_cycle_timer
    import neopixel_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_W
) (
    input  logic             clk_i,
    input  logic             sys_rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!sys_rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/neopixel_frame_sched.sv
// ============================================================================
// neopixel_frame_sched: per-frame arbiter feeding the RGB/cmd FIFOs and gating tx_enable
// Rev 1.0
// ============================================================================
`default_nettype none

module neopixel_frame_sched
    import neopixel_pkg::*;
#(
    parameter int unsigned FIFO_AW      = 10,
    parameter int unsigned TAIL_CYCLES  = DEF_TAIL_CYCLES,
    parameter int unsigned LATCH_CYCLES = DEF_LATCH_CYCLES
) (
    input  logic               clk_i,
    input  logic               sys_rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [NUM_REQ-1:0] last_i,
    input  logic [23:0]        rgb0_i,
    input  logic [23:0]        rgb1_i,
    input  logic [NUM_REQ-1:0] cmd_i,
    output logic [NUM_REQ-1:0] ready_o,
    input  logic               abort_i,
    input  logic               fifo_full_i,
    input  logic               fifo_empty_i,
    output logic               fifo_wr_en_o,
    output logic [23:0]        fifo_rgb_o,
    output logic               fifo_cmd_o,
    output logic               fifo_rst_o,
    output logic               tx_enable_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               frame_done_o,
    output logic               busy_o,
    output logic               overflow_o
);

    localparam logic [FIFO_AW:0]     PIX_ONE    = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]     PIX_LAST   = (FIFO_AW+1)'((1 << FIFO_AW) - 1);
    localparam logic [TIMER_W-1:0]   TAIL_LOAD  = TIMER_W'(TAIL_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   LATCH_LOAD = TIMER_W'(LATCH_CYCLES - 1);

    state_e               state_q, state_d;
    logic                 gidx_q, gidx_d;
    logic                 prio_q, prio_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [FIFO_AW:0]     pix_cnt_q, pix_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 abort_rst_q, abort_rst_d;
    logic                 tmr_load;
    logic [TIMER_W-1:0]   tmr_val;
    logic                 tmr_zero;

    neopixel_cycle_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk_i      (clk_i),
        .sys_rst_i  (sys_rst_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        gidx_d       = gidx_q;
        prio_d       = prio_q;
        grant_d      = grant_q;
        pix_cnt_d    = pix_cnt_q;
        overflow_d   = overflow_q;
        abort_rst_d  = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = LATCH_LOAD;
        ready_o      = '0;
        fifo_wr_en_o = 1'b0;
        frame_done_o = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    gidx_d  = req_i[prio_q] ? prio_q : ~prio_q;
                    grant_d = req_onehot(gidx_d);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ready_o[gidx_q] = ~fifo_full_i;
                // Abort beats a simultaneous last: the pixel on the bus is dropped.
                if (abort_i) begin
                    state_d     = ST_LATCH;
                    tmr_load    = 1'b1;
                    abort_rst_d = 1'b1;
                end else if (valid_i[gidx_q] && !fifo_full_i) begin
                    fifo_wr_en_o = 1'b1;
                    pix_cnt_d    = pix_cnt_q + PIX_ONE;
                    if (last_i[gidx_q]) begin
                        state_d = ST_DRAIN;
                    end else if (pix_cnt_q == PIX_LAST) begin
                        overflow_d = 1'b1;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort_i) begin
                    state_d     = ST_LATCH;
                    tmr_load    = 1'b1;
                    abort_rst_d = 1'b1;
                end else if (fifo_empty_i) begin
                    state_d  = ST_TAIL;
                    tmr_load = 1'b1;
                    tmr_val  = TAIL_LOAD;
                end
            end
            ST_TAIL: begin
                if (abort_i) begin
                    state_d     = ST_LATCH;
                    tmr_load    = 1'b1;
                    abort_rst_d = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = ST_LATCH;
                    tmr_load = 1'b1;
                end
            end
            ST_LATCH: begin
                if (tmr_zero) begin
                    frame_done_o = 1'b1;
                    state_d      = ST_IDLE;
                    grant_d      = '0;
                    prio_d       = ~gidx_q;
                    pix_cnt_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!sys_rst_i) begin
            state_q     <= ST_IDLE;
            gidx_q      <= 1'b0;
            prio_q      <= 1'b0;
            grant_q     <= '0;
            pix_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            abort_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gidx_q      <= gidx_d;
            prio_q      <= prio_d;
            grant_q     <= grant_d;
            pix_cnt_q   <= pix_cnt_d;
            overflow_q  <= overflow_d;
            abort_rst_q <= abort_rst_d;
        end
    end

    // tx_enable follows registered state only, so it can never rise while pixels are loading.
    assign tx_enable_o = (state_q == ST_DRAIN) || (state_q == ST_TAIL);
    assign busy_o      = (state_q != ST_IDLE);
    assign grant_o     = grant_q;
    assign overflow_o  = overflow_q;
    assign fifo_rst_o  = ~sys_rst_i | abort_rst_q;
    assign fifo_rgb_o  = gidx_q ? rgb1_i : rgb0_i;
    assign fifo_cmd_o  = cmd_i[gidx_q];

endmodule

`default_nettype wire
